uart_link: RTL

Parametrised UART link between the EGO1 board and the host control application, replacing the fixed 9600-baud, 8-bit transceiver wrapper. Runs entirely on the system clock, using tick enables instead of divided clocks. Sends the car's command byte on request or on a periodic heartbeat, with an optional forced check bit and optional parity. Receives the sensor byte with framing and parity checks, and reports link liveness from a receive timeout.

---
 rtl/uart_link_pkg.sv | 22 ++
 rtl/uart_link_tick.sv | 31 +++
 rtl/uart_link.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/uart_link_pkg.sv
// rtl/uart_link_pkg.sv - shared constants, state types and divisor helper for uart_link
package uart_link_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;
    localparam int OS       = 16;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    // Rounded clock divisor for an enable firing at rate_hz.
    function automatic int calc_div(input int clk_hz, input int rate_hz);
        return (clk_hz + rate_hz / 2) / rate_hz;
    endfunction

endpackage

// File: rtl/uart_link_tick.sv
// rtl/uart_link_tick.sv - oversample (tick16) and 1 ms enable generator
module uart_link_tick #(
    parameter int DIV    = 651,
    parameter int MS_DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick16,
    output logic tick_ms
);

    localparam int BW = $clog2(DIV + 1);
    localparam int MW = $clog2(MS_DIV + 1);

    logic [BW-1:0] baud_cnt;
    logic [MW-1:0] ms_cnt;

    assign tick16  = (baud_cnt == BW'(DIV - 1));
    assign tick_ms = (ms_cnt == MW'(MS_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            ms_cnt   <= '0;
        end else begin
            baud_cnt <= tick16  ? '0 : baud_cnt + 1'b1;
            ms_cnt   <= tick_ms ? '0 : ms_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_link.sv
// rtl/uart_link.sv - UART link: heartbeat/on-demand command TX, checked sensor RX, link liveness
module uart_link
    import uart_link_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int BAUD           = 9600,
    parameter int DATA_W         = 8,
    parameter int PARITY         = 0,
    parameter int FORCE_MSB      = 1,
    parameter int SEND_PERIOD_MS = 1,
    parameter int RX_TIMEOUT_MS  = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_send,
    output logic              tx_busy,
    output logic              txd,
    input  logic              rxd,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_err,
    output logic              link_up
);

    localparam int DIV    = calc_div(CLK_HZ, BAUD * OS);
    localparam int MS_DIV = calc_div(CLK_HZ, 1000);
    localparam bit PAR_EN = (PARITY != PAR_NONE);
    localparam bit PAR_OD = (PARITY == PAR_ODD);
    localparam int BIW    = $clog2(DATA_W);

    logic tick16, tick_ms;

    uart_link_tick #(.DIV(DIV), .MS_DIV(MS_DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .tick16  (tick16),
        .tick_ms (tick_ms)
    );

    tx_state_t         tx_state, tx_next;
    logic [3:0]        tx_tcnt;
    logic [BIW-1:0]    tx_bit;
    logic [DATA_W-1:0] tx_shreg, tx_word;
    logic              tx_par, tx_pend, tx_req, tx_bit_end, tx_load, hb_fire;
    logic [31:0]       hb_cnt;

    always_comb begin
        tx_word = tx_data;
        if (FORCE_MSB != 0) tx_word[DATA_W-1] = 1'b1;
    end

    assign hb_fire    = (SEND_PERIOD_MS != 0) && tick_ms && (hb_cnt == 32'(SEND_PERIOD_MS - 1));
    assign tx_req     = tx_send | hb_fire;
    assign tx_bit_end = tick16 && (tx_tcnt == 4'(OS - 1));
    // A waiting request launches on any tick from IDLE, or straight out of STOP for back-to-back frames.
    assign tx_load    = tick16 && (tx_pend || tx_req) &&
                        ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_tcnt == 4'(OS - 1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_tcnt  <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            tx_par   <= 1'b0;
            tx_pend  <= 1'b0;
            hb_cnt   <= '0;
        end else begin
            tx_state <= tx_next;
            tx_pend  <= !tx_load && (tx_pend || tx_req);
            if (tick_ms)
                hb_cnt <= (hb_cnt == 32'(SEND_PERIOD_MS - 1)) ? '0 : hb_cnt + 32'd1;
            if (tx_load) begin
                tx_tcnt  <= '0;
                tx_bit   <= '0;
                tx_shreg <= tx_word;
                tx_par   <= ^tx_word ^ PAR_OD;
            end else if (tick16 && tx_state != TX_IDLE) begin
                tx_tcnt <= tx_tcnt + 4'd1;
                if (tx_bit_end && tx_state == TX_DATA) begin
                    tx_shreg <= tx_shreg >> 1;
                    tx_bit   <= tx_bit + 1'b1;
                end
            end
        end
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:   if (tx_load) tx_next = TX_START;
            TX_START:  if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA:   if (tx_bit_end && tx_bit == BIW'(DATA_W - 1))
                           tx_next = PAR_EN ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
            TX_STOP:   if (tx_load) tx_next = TX_START;
                       else if (tx_bit_end) tx_next = TX_IDLE;
            default:   tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        txd = 1'b1;
        case (tx_state)
            TX_START:  txd = 1'b0;
            TX_DATA:   txd = tx_shreg[0];
            TX_PARITY: txd = tx_par;
            default:   txd = 1'b1;
        endcase
    end

    assign tx_busy = (tx_state != TX_IDLE) || tx_pend;

    rx_state_t         rx_state, rx_next;
    logic              rx_s1, rx_s2, rx_prev;
    logic [3:0]        rx_tcnt;
    logic [BIW-1:0]    rx_bit;
    logic [DATA_W-1:0] rx_shreg;
    logic              rx_par, rx_fall, rx_sample, rx_good, rx_ok_stb, rx_err_stb;
    logic [31:0]       to_cnt;

    assign rx_fall   = rx_prev && !rx_s2;
    // First sample lands mid start bit, every later one a full bit after it.
    assign rx_sample = tick16 && ((rx_state == RX_START) ? (rx_tcnt == 4'(OS / 2 - 1))
                                                         : (rx_tcnt == 4'(OS - 1)));
    assign rx_good   = rx_s2 && (!PAR_EN || ((^rx_shreg ^ rx_par) == PAR_OD));

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_tcnt  <= '0;
            rx_bit   <= '0;
            rx_shreg <= '0;
            rx_par   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            to_cnt   <= '0;
        end else begin
            rx_s1    <= rxd;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_next;
            if (rx_state == RX_IDLE)
                rx_tcnt <= '0;
            else if (tick16)
                rx_tcnt <= (rx_state == RX_START && rx_sample) ? '0 : rx_tcnt + 4'd1;
            if (rx_state == RX_IDLE) begin
                rx_bit <= '0;
            end else if (rx_sample && rx_state == RX_DATA) begin
                rx_shreg <= {rx_s2, rx_shreg[DATA_W-1:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
            if (rx_sample && rx_state == RX_PARITY) rx_par <= rx_s2;
            rx_valid <= rx_ok_stb;
            rx_err   <= rx_err_stb;
            if (rx_ok_stb) rx_data <= rx_shreg;
            if (rx_valid)
                to_cnt <= 32'(RX_TIMEOUT_MS);
            else if (tick_ms && to_cnt != 32'd0)
                to_cnt <= to_cnt - 32'd1;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:   if (rx_fall) rx_next = RX_START;
            RX_START:  if (rx_sample) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_sample && rx_bit == BIW'(DATA_W - 1))
                           rx_next = PAR_EN ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_sample) rx_next = RX_STOP;
            RX_STOP:   if (rx_sample) rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_ok_stb  = 1'b0;
        rx_err_stb = 1'b0;
        if (rx_state == RX_STOP && rx_sample) begin
            rx_ok_stb  = rx_good;
            rx_err_stb = !rx_good;
        end
    end

    assign link_up = (to_cnt != 32'd0);

endmodule
